// File: rtl/io_responder_pkg.sv
// Shared definitions for the I/O page responder.
//  - CPU-visible register addresses of the I/O page (0x7000-0x7003)
//  - gamepad poll FSM state encodings
//  - button bit positions inside a pad snapshot (1 = pressed)
//  - small helper to zero-extend a status bit onto the 8-bit data bus
package io_responder_pkg;

  localparam logic [15:0] ADDR_IN_VBLANK      = 16'h7000;
  localparam logic [15:0] ADDR_CLR_VBLANK_IRQ = 16'h7001;
  localparam logic [15:0] ADDR_CONTROLLER_1   = 16'h7002;
  localparam logic [15:0] ADDR_CONTROLLER_2   = 16'h7003;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // First serial bit lands in bit 7.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  function automatic logic [7:0] status_byte(input logic b);
    return {7'b0, b};
  endfunction

endpackage

// File: rtl/io_responder_controller_poller.sv
// controller_poller: serial gamepad poll sequencer for two pads sharing
// latch and clock lines.
//  clk, rst          : clock, synchronous active-high reset
//  start             : one-clk request (vblank rise); ignored unless idle
//  pad1/2_data_n     : serial pad data, active low
//  pad_latch,pad_clk : registered strobes to both pads
//  poll_busy         : sequence in progress
//  snap1, snap2      : last complete button snapshots (1 = pressed)
module controller_poller
  import io_responder_pkg::*;
#(
  parameter int HALF_PERIOD = 6,
  parameter int NUM_BUTTONS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pad1_data_n,
  input  logic                   pad2_data_n,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic                   poll_busy,
  output logic [NUM_BUTTONS-1:0] snap1,
  output logic [NUM_BUTTONS-1:0] snap2
);

  localparam int CW = $clog2(2*HALF_PERIOD+1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2*HALF_PERIOD-1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD-1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_BUTTONS-1);

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [NUM_BUTTONS-1:0] snap1_q, snap1_d, snap2_q, snap2_d;
  logic                   pad_latch_q, pad_latch_d;
  logic                   pad_clk_q, pad_clk_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_LOW: begin
        // Sample at the end of the low phase, just before the rising shift edge.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          sh1_d[IDX_LAST - idx_q] = ~pad1_data_n;
          sh2_d[IDX_LAST - idx_q] = ~pad2_data_n;
          state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOW;
        end
      end
      ST_DONE: begin
        // Both snapshots swap together so CPU reads never see a partial poll.
        cnt_d   = '0;
        snap1_d = sh1_q;
        snap2_d = sh2_q;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d == ST_HIGH);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      snap1_q     <= '0;
      snap2_q     <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      snap1_q     <= snap1_d;
      snap2_q     <= snap2_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign poll_busy = busy_q;
  assign snap1     = snap1_q;
  assign snap2     = snap2_q;

endmodule

// File: rtl/io_responder.sv
// io_responder: CPU-side responder for the I/O page 0x7000-0x7003.
//  cpu_access/cpu_rw/SELECT_* : bus strobe, direction, decoded selects
//  vblank                     : video vblank level
//  pad1/2_data_n              : serial gamepad data, active low
//  pad_latch, pad_clk         : gamepad strobes
//  cpu_data_out, cpu_data_oe  : read data and its drive enable
//  irq_n                      : active-low vblank IRQ
//  poll_busy                  : gamepad poll in progress
module io_responder
  import io_responder_pkg::*;
#(
  parameter int HALF_PERIOD = 6,
  parameter int NUM_BUTTONS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_access,
  input  logic       cpu_rw,
  input  logic       SELECT_in_vblank,
  input  logic       SELECT_clr_vblank_irq,
  input  logic       SELECT_controller_1,
  input  logic       SELECT_controller_2,
  input  logic       vblank,
  input  logic       pad1_data_n,
  input  logic       pad2_data_n,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] cpu_data_out,
  output logic       cpu_data_oe,
  output logic       irq_n,
  output logic       poll_busy
);

  logic       vblank_q, pending_q, pending_d, irq_n_q;
  logic       rise, clr;
  logic [7:0] snap1, snap2;

  assign rise = vblank & ~vblank_q;
  assign clr  = cpu_access & SELECT_clr_vblank_irq;

  // A new vblank beats a simultaneous acknowledge so no frame is lost.
  always_comb begin
    pending_d = pending_q;
    if (clr)  pending_d = 1'b0;
    if (rise) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      vblank_q  <= vblank;
      pending_q <= pending_d;
      irq_n_q   <= ~pending_q;
    end
  end

  assign irq_n = irq_n_q;

  controller_poller #(
    .HALF_PERIOD (HALF_PERIOD),
    .NUM_BUTTONS (NUM_BUTTONS)
  ) u_poller (
    .clk         (clk),
    .rst         (rst),
    .start       (rise),
    .pad1_data_n (pad1_data_n),
    .pad2_data_n (pad2_data_n),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .poll_busy   (poll_busy),
    .snap1       (snap1),
    .snap2       (snap2)
  );

  always_comb begin
    cpu_data_out = 8'h00;
    cpu_data_oe  = 1'b0;
    if (cpu_access && cpu_rw) begin
      if (SELECT_in_vblank) begin
        cpu_data_out = status_byte(vblank);
        cpu_data_oe  = 1'b1;
      end else if (SELECT_clr_vblank_irq) begin
        cpu_data_out = status_byte(pending_q);
        cpu_data_oe  = 1'b1;
      end else if (SELECT_controller_1) begin
        cpu_data_out = snap1;
        cpu_data_oe  = 1'b1;
      end else if (SELECT_controller_2) begin
        cpu_data_out = snap2;
        cpu_data_oe  = 1'b1;
      end
    end
  end

endmodule
